// File: rtl/layer_2_pkg.sv
// Shared constants and state encoding for the layer-2 activation stage.
// Later layers reuse these through import layer_2_pkg::*.
package layer_2_pkg;

    localparam int ACC_WIDTH = 17;
    localparam int OUT_WIDTH = 8;
    localparam int NUM_LANES = 5;
    localparam int LANE_W    = 3;

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_PROC  = 2'd1,
        S_OUT   = 2'd2,
        S_CLEAR = 2'd3
    } state_e;

endpackage

// File: rtl/relu_shift_sat.sv
// Bias add, ReLU, arithmetic right shift and positive saturation for one lane.
// Purely combinational; the caller registers the result.
module relu_shift_sat #(
    parameter int ACC_W  = 17,
    parameter int BIAS_W = 8,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 4
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [BIAS_W-1:0] bias,
    output logic signed [OUT_W-1:0]  result
);

    // One extra bit of headroom so the bias add can never wrap.
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] MAX_POS = SUM_W'((1 << (OUT_W - 1)) - 1);

    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] shifted_s;

    // Sign-extend both operands, add, then clamp into the output range.
    always_comb begin
        sum_s     = {acc[ACC_W-1], acc} + {{(SUM_W - BIAS_W){bias[BIAS_W-1]}}, bias};
        shifted_s = sum_s >>> SHIFT;
        if (sum_s[SUM_W-1]) begin
            result = '0;
        end else if (shifted_s > MAX_POS) begin
            result = MAX_POS[OUT_W-1:0];
        end else begin
            result = shifted_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/layer_2_5_activate.sv
// Layer-2 activation stage: counts accumulate pulses, snapshots the five lanes,
// then streams bias+ReLU+shift+saturate results one lane at a time.
module layer_2_5_activate
    import layer_2_pkg::*;
#(
    parameter int BIAS_WIDTH = 8,
    parameter int NUM_INPUTS = 16,
    parameter int SHIFT      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic signed [ACC_WIDTH-1:0]       accumulate_1,
    input  logic signed [ACC_WIDTH-1:0]       accumulate_2,
    input  logic signed [ACC_WIDTH-1:0]       accumulate_3,
    input  logic signed [ACC_WIDTH-1:0]       accumulate_4,
    input  logic signed [ACC_WIDTH-1:0]       accumulate_5,
    input  logic                              accumulate_signal,
    input  logic [NUM_LANES*BIAS_WIDTH-1:0]   bias_in,
    output logic signed [OUT_WIDTH-1:0]       out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANE_W-1:0]                 out_index,
    output logic                              out_last,
    output logic                              acc_clear,
    output logic                              overrun
);

    localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_INPUTS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [LANE_W-1:0]               lane_q, lane_d;
    logic signed [ACC_WIDTH-1:0]     acc_q  [NUM_LANES];
    logic signed [ACC_WIDTH-1:0]     acc_d  [NUM_LANES];
    logic signed [BIAS_WIDTH-1:0]    bias_q [NUM_LANES];
    logic signed [BIAS_WIDTH-1:0]    bias_d [NUM_LANES];
    logic signed [OUT_WIDTH-1:0]     out_data_q, out_data_d;
    logic                            out_valid_q, out_valid_d;
    logic [LANE_W-1:0]               out_index_q, out_index_d;
    logic                            out_last_q, out_last_d;
    logic                            acc_clear_q, acc_clear_d;
    logic                            overrun_q, overrun_d;

    logic signed [ACC_WIDTH-1:0]     acc_in_s [NUM_LANES];
    logic signed [ACC_WIDTH-1:0]     acc_sel_s;
    logic signed [BIAS_WIDTH-1:0]    bias_sel_s;
    logic signed [OUT_WIDTH-1:0]     act_s;

    assign acc_in_s[0] = accumulate_1;
    assign acc_in_s[1] = accumulate_2;
    assign acc_in_s[2] = accumulate_3;
    assign acc_in_s[3] = accumulate_4;
    assign acc_in_s[4] = accumulate_5;

    // Pick the snapshot for the lane currently being processed.
    always_comb begin
        case (lane_q)
            3'd0:    begin acc_sel_s = acc_q[0]; bias_sel_s = bias_q[0]; end
            3'd1:    begin acc_sel_s = acc_q[1]; bias_sel_s = bias_q[1]; end
            3'd2:    begin acc_sel_s = acc_q[2]; bias_sel_s = bias_q[2]; end
            3'd3:    begin acc_sel_s = acc_q[3]; bias_sel_s = bias_q[3]; end
            3'd4:    begin acc_sel_s = acc_q[4]; bias_sel_s = bias_q[4]; end
            default: begin acc_sel_s = '0;       bias_sel_s = '0;        end
        endcase
    end

    relu_shift_sat #(
        .ACC_W  (ACC_WIDTH),
        .BIAS_W (BIAS_WIDTH),
        .OUT_W  (OUT_WIDTH),
        .SHIFT  (SHIFT)
    ) u_relu_shift_sat (
        .acc    (acc_sel_s),
        .bias   (bias_sel_s),
        .result (act_s)
    );

    // Next-state and next-output logic for the pulse-count / stream FSM.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        lane_d      = lane_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        acc_clear_d = 1'b0;
        // Pulses outside S_ACC belong to no group; flag them and never count them.
        overrun_d   = overrun_q | (accumulate_signal & (state_q != S_ACC));

        case (state_q)
            S_ACC: begin
                if (accumulate_signal) begin
                    if (count_q == CNT_LAST) begin
                        count_d = '0;
                        lane_d  = '0;
                        state_d = S_PROC;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            acc_d[i]  = acc_in_s[i];
                            bias_d[i] = bias_in[i*BIAS_WIDTH +: BIAS_WIDTH];
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    count_d = count_q;
                end
            end
            S_PROC: begin
                out_data_d  = act_s;
                out_index_d = lane_q;
                out_last_d  = (lane_q == LAST_LANE);
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (lane_q == LAST_LANE) begin
                        state_d     = S_CLEAR;
                        acc_clear_d = 1'b1;
                    end else begin
                        lane_d  = lane_q + 1'b1;
                        state_d = S_PROC;
                    end
                end else begin
                    state_d = S_OUT;
                end
            end
            S_CLEAR: begin
                state_d = S_ACC;
            end
            default: begin
                state_d     = S_ACC;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_ACC;
            count_q     <= '0;
            lane_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            acc_clear_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                acc_q[i]  <= '0;
                bias_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            acc_clear_q <= acc_clear_d;
            overrun_q   <= overrun_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign acc_clear = acc_clear_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_layer_2_5_activate.sv
// Self-checking bench for layer_2_5_activate: directed groups plus random groups
// compared against an arithmetic reference of bias/ReLU/shift/saturate.
module tb_layer_2_5_activate;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [16:0] acc_in [5];
    logic               accumulate_signal;
    logic [39:0]        bias_in;
    logic signed [7:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         out_index;
    logic               out_last;
    logic               acc_clear;
    logic               overrun;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic signed [16:0] grp_acc  [5];
    logic signed [7:0]  grp_bias [5];
    int                 exp_v    [5];

    always #5 clk = ~clk;

    layer_2_5_activate dut (
        .clk               (clk),
        .reset             (reset),
        .accumulate_1      (acc_in[0]),
        .accumulate_2      (acc_in[1]),
        .accumulate_3      (acc_in[2]),
        .accumulate_4      (acc_in[3]),
        .accumulate_5      (acc_in[4]),
        .accumulate_signal (accumulate_signal),
        .bias_in           (bias_in),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_index         (out_index),
        .out_last          (out_last),
        .acc_clear         (acc_clear),
        .overrun           (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int a, input int b);
        int s;
        int r;
        s = a + b;
        if (s < 0) r = 0;
        else r = s / 16;
        if (r > 127) r = 127;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 5; i++) acc_in[i] = 17'($urandom_range(0, 131071));
        bias_in = {$urandom, $urandom};
    endtask

    // 15 filler pulses, then the capturing pulse carrying grp_acc / grp_bias.
    task automatic run_pulses();
        for (int p = 0; p < 15; p++) begin
            scramble_inputs();
            accumulate_signal = 1'b1;
            tick();
            accumulate_signal = 1'b0;
            chk($sformatf("early_valid_p%0d", p), out_valid, 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int i = 0; i < 5; i++) begin
            acc_in[i]           = grp_acc[i];
            bias_in[i*8 +: 8]   = grp_bias[i];
        end
        accumulate_signal = 1'b1;
        tick();
        accumulate_signal = 1'b0;
        scramble_inputs();
        chk("latency_cyc1_valid", out_valid, 0);
        tick();
        chk("latency_cyc2_valid", out_valid, 1);
    endtask

    task automatic drain(input int stall_lane, input int stall_n, input bit poke);
        for (int lane = 0; lane < 5; lane++) begin
            int w;
            w = 0;
            while (!out_valid && w < 8) begin
                tick();
                w++;
            end
            chk($sformatf("valid_l%0d", lane), out_valid, 1);
            chk($sformatf("data_l%0d", lane), out_data, exp_v[lane]);
            chk($sformatf("index_l%0d", lane), out_index, lane);
            chk($sformatf("last_l%0d", lane), out_last, (lane == 4) ? 1 : 0);
            if (lane == stall_lane) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    if (poke && s == 0) accumulate_signal = 1'b1;
                    tick();
                    accumulate_signal = 1'b0;
                    if (poke && s == 0) chk("overrun_set", overrun, 1);
                    chk($sformatf("hold_valid_l%0d", lane), out_valid, 1);
                    chk($sformatf("hold_data_l%0d", lane), out_data, exp_v[lane]);
                    chk($sformatf("hold_index_l%0d", lane), out_index, lane);
                end
            end
            out_ready = 1'b1;
            tick();
            chk($sformatf("valid_drop_l%0d", lane), out_valid, 0);
            if (lane == 4) begin
                out_ready = 1'b0;
                chk("acc_clear_high", acc_clear, 1);
                tick();
                chk("acc_clear_low", acc_clear, 0);
            end else begin
                chk($sformatf("acc_clear_idle_l%0d", lane), acc_clear, 0);
            end
        end
    endtask

    task automatic random_group();
        for (int i = 0; i < 5; i++) begin
            grp_acc[i]  = 17'($urandom_range(0, 131071));
            grp_bias[i] = 8'($urandom_range(0, 255));
            exp_v[i]    = model(int'(grp_acc[i]), int'(grp_bias[i]));
        end
    endtask

    initial begin
        reset             = 1'b1;
        accumulate_signal = 1'b0;
        out_ready         = 1'b0;
        bias_in           = '0;
        for (int i = 0; i < 5; i++) acc_in[i] = '0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        chk("rst_last", out_last, 0);
        chk("rst_clear", acc_clear, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        tick();

        // Directed group with hand-computed results; lane 2 stalls 5 cycles with an overrun poke.
        grp_acc[0] = 17'sd1000;   grp_bias[0] = 8'sd24;
        grp_acc[1] = -17'sd500;   grp_bias[1] = 8'sd10;
        grp_acc[2] = 17'sd65535;  grp_bias[2] = 8'sd0;
        grp_acc[3] = 17'sd16;     grp_bias[3] = -8'sd1;
        grp_acc[4] = 17'sd31;     grp_bias[4] = 8'sd1;
        exp_v[0] = 64; exp_v[1] = 0; exp_v[2] = 127; exp_v[3] = 0; exp_v[4] = 2;
        out_ready = 1'b1;
        run_pulses();
        chk("overrun_before_poke", overrun, 0);
        drain(2, 5, 1'b1);
        chk("overrun_sticky", overrun, 1);

        // A second group: poked pulse must not have been counted.
        random_group();
        run_pulses();
        drain(1, 2, 1'b0);
        chk("overrun_still_sticky", overrun, 1);

        // Reset while a result is waiting.
        random_group();
        out_ready = 1'b0;
        run_pulses();
        chk("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_clear", acc_clear, 0);
        chk("async_rst_overrun", overrun, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_valid", out_valid, 0);

        // Fresh random groups after reset with random stalls.
        for (int g = 0; g < 4; g++) begin
            random_group();
            run_pulses();
            drain(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b0);
            chk($sformatf("overrun_clean_g%0d", g), overrun, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
